// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame checker: FSM state encoding
// and width-generic saturating counter arithmetic.
package parity_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // All-ones value of a w-bit counter, carried in 32 bits (w <= 32).
    function automatic logic [31:0] cnt_max(input int unsigned w);
        logic [31:0] m;
        if (w >= 32) begin
            m = '1;
        end else begin
            m = (32'd1 << w) - 32'd1;
        end
        return m;
    endfunction

    function automatic logic is_max(input logic [31:0] v, input int unsigned w);
        return (v == cnt_max(w));
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        if (is_max(v, w)) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_xnor_reduce.sv
// Combinational reduction of one data word to its XOR and XNOR parity.
module word_xnor_reduce #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic             xor_out,
    output logic             xnor_out
);

    assign xor_out  = ^data;
    assign xnor_out = ~(^data);

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming per-frame XNOR parity checker with a saturating beat count and a
// single registered result slot under valid/ready backpressure.
module parity_frame_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_xnor,
    output logic             out_err,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    import parity_pkg::*;

    state_t           state, state_next;
    logic             acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ovf, ovf_next;

    logic             word_xor;
    logic             word_xnor;
    logic             acc_fire;
    logic             acc_eff;
    logic [CNT_W-1:0] cnt_eff;
    logic             ovf_eff;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_inc;

    logic             load_res;
    logic             res_xnor;
    logic             res_err;
    logic [CNT_W-1:0] res_beats;
    logic             res_ovf;

    word_xnor_reduce #(
        .WIDTH(WIDTH)
    ) u_reduce (
        .data    (in_data),
        .xor_out (word_xor),
        .xnor_out(word_xnor)
    );

    // A pending result blocks new beats, so the accumulator freezes during a stall.
    assign in_ready = !out_valid || out_ready;
    assign acc_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    // In IDLE the running state is treated as empty so a new frame starts clean.
    always_comb begin
        acc_eff   = (state == ST_ACCUM) ? acc : 1'b0;
        cnt_eff   = (state == ST_ACCUM) ? cnt : '0;
        ovf_eff   = (state == ST_ACCUM) ? ovf : 1'b0;
        cnt_full  = is_max(32'(cnt_eff), CNT_W);
        cnt_inc   = CNT_W'(sat_inc(32'(cnt_eff), CNT_W));

        res_xnor  = acc_eff ^ word_xnor;
        res_err   = res_xnor ^ in_par;
        res_beats = cnt_inc;
        res_ovf   = ovf_eff || cnt_full;

        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        load_res   = 1'b0;

        if (acc_fire) begin
            if (in_last) begin
                state_next = ST_IDLE;
                acc_next   = 1'b0;
                cnt_next   = '0;
                ovf_next   = 1'b0;
                load_res   = 1'b1;
            end else begin
                state_next = ST_ACCUM;
                acc_next   = acc_eff ^ word_xor;
                cnt_next   = cnt_inc;
                ovf_next   = ovf_eff || cnt_full;
            end
        end
    end

    // A load in the same cycle as a consume overwrites the slot and keeps it valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_xnor  <= 1'b0;
            out_err   <= 1'b0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (load_res) begin
            out_valid <= 1'b1;
            out_xnor  <= res_xnor;
            out_err   <= res_err;
            out_beats <= res_beats;
            out_ovf   <= res_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (WIDTH=4, CNT_W=2).
module tb_parity_frame_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_xnor;
    logic             out_err;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    int tests;
    int failed;

    parity_frame_checker #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_par   (in_par),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_xnor (out_xnor),
        .out_err  (out_err),
        .out_beats(out_beats),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for exactly one clock edge, then returns 1 ns after it.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last, input logic par);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        in_par   = par;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_par   = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_par    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_xnor",  8'(out_xnor),  8'd0);
        checkOutput("rst_err",   8'(out_err),   8'd0);
        checkOutput("rst_beats", 8'(out_beats), 8'd0);
        checkOutput("rst_ovf",   8'(out_ovf),   8'd0);
        checkOutput("rst_ready", 8'(in_ready),  8'd1);
        rst = 1'b0;

        // single-beat frame, two ones -> xnor 1, matches par 1
        applyStimulus(4'b0011, 1'b1, 1'b1);
        checkOutput("single_valid", 8'(out_valid), 8'd1);
        checkOutput("single_xnor",  8'(out_xnor),  8'd1);
        checkOutput("single_err",   8'(out_err),   8'd0);
        checkOutput("single_beats", 8'(out_beats), 8'd1);
        checkOutput("single_ovf",   8'(out_ovf),   8'd0);

        // three-beat frame with 8 ones, par 0 -> error
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("three_consumed", 8'(out_valid), 8'd0);
        applyStimulus(4'b0111, 1'b0, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("three_valid", 8'(out_valid), 8'd1);
        checkOutput("three_xnor",  8'(out_xnor),  8'd1);
        checkOutput("three_err",   8'(out_err),   8'd1);
        checkOutput("three_beats", 8'(out_beats), 8'd3);
        checkOutput("three_ovf",   8'(out_ovf),   8'd0);

        // backpressure: pending result holds, presented beat is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b0110;
        in_last   = 1'b1;
        in_par    = 1'b1;
        #1;
        checkOutput("bp_in_ready_low", 8'(in_ready), 8'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_hold_valid", 8'(out_valid), 8'd1);
        checkOutput("bp_hold_beats", 8'(out_beats), 8'd3);
        checkOutput("bp_hold_err",   8'(out_err),   8'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", 8'(in_ready), 8'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_par   = 1'b0;
        checkOutput("bp_new_valid", 8'(out_valid), 8'd1);
        checkOutput("bp_new_xnor",  8'(out_xnor),  8'd1);
        checkOutput("bp_new_err",   8'(out_err),   8'd0);
        checkOutput("bp_new_beats", 8'(out_beats), 8'd1);

        // saturation: five beats of one '1' each with a 2-bit counter
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
        end
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("sat_valid", 8'(out_valid), 8'd1);
        checkOutput("sat_beats", 8'(out_beats), 8'd3);
        checkOutput("sat_ovf",   8'(out_ovf),   8'd1);
        checkOutput("sat_xnor",  8'(out_xnor),  8'd0);
        checkOutput("sat_err",   8'(out_err),   8'd0);

        // reset mid-frame discards the partial frame
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", 8'(out_valid), 8'd0);
        rst = 1'b0;
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("midrst_beats", 8'(out_beats), 8'd1);
        checkOutput("midrst_xnor",  8'(out_xnor),  8'd0);
        checkOutput("midrst_err",   8'(out_err),   8'd1);
        checkOutput("midrst_ovf",   8'(out_ovf),   8'd0);

        // reset drops a pending, unconsumed result
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("droprst_valid", 8'(out_valid), 8'd0);
        checkOutput("droprst_ready", 8'(in_ready),  8'd1);
        out_ready = 1'b1;

        // back-to-back single-beat frames with simultaneous consume and load
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("b2b_first_valid", 8'(out_valid), 8'd1);
        checkOutput("b2b_first_xnor",  8'(out_xnor),  8'd1);
        checkOutput("b2b_first_err",   8'(out_err),   8'd0);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        checkOutput("b2b_second_valid", 8'(out_valid), 8'd1);
        checkOutput("b2b_second_xnor",  8'(out_xnor),  8'd0);
        checkOutput("b2b_second_err",   8'(out_err),   8'd1);
        checkOutput("b2b_second_beats", 8'(out_beats), 8'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_drain_valid", 8'(out_valid), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
